// File: rtl/hazard_scoreboard.sv
// ============================================================================
// hazard_scoreboard
//
// Tracks register writers in flight past ID (S1 youngest .. SN oldest) and
// decides, for the instruction sitting in ID, whether each source can be
// forwarded from a stage result, read from the register file, or must wait
// (stall). Optionally keeps the LL/SC link flag.
//
// Optional feature macro: SCOREBOARD_ATOMIC_EN
//   defined     -> link register implemented (o_atomic, o_sc_mask live)
//   not defined -> o_atomic = 0, o_sc_mask = 0, i_id_ll / i_snoop_inv ignored
//
// Parameters
//   NUM_STAGES  writer stages tracked past ID (2..8)
//   LOAD_READY  first stage index whose load data is forwardable (1..NUM_STAGES)
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   i_id_valid                 ID holds a real instruction
//   i_id_rs_addr/i_id_rt_addr  source register numbers
//   i_id_rs_used/i_id_rt_used  source actually read
//   i_id_we, i_id_waddr        destination write enable / register
//   i_id_load                  load (decoder raises it for LL as well)
//   i_id_ll, i_id_sc           load-linked / store-conditional
//   i_id_store                 plain store (SW, SB)
//   i_flush                    squash every tracked entry
//   i_snoop_inv                external write to the linked line
//   o_stall                    hold PC and ID, bubble into S1
//   o_fwd_rs_sel/o_fwd_rt_sel  0 = register file, k = result of stage Sk
//   o_atomic                   link flag valid
//   o_sc_mask                  suppress the current SC's store
// ============================================================================
module hazard_scoreboard #(
    parameter  int NUM_STAGES = 3,
    parameter  int LOAD_READY = 2,
    localparam int SEL_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_id_valid,
    input  logic [4:0]       i_id_rs_addr,
    input  logic [4:0]       i_id_rt_addr,
    input  logic             i_id_rs_used,
    input  logic             i_id_rt_used,
    input  logic             i_id_we,
    input  logic [4:0]       i_id_waddr,
    input  logic             i_id_load,
    input  logic             i_id_ll,
    input  logic             i_id_sc,
    input  logic             i_id_store,
    input  logic             i_flush,
    input  logic             i_snoop_inv,
    output logic             o_stall,
    output logic [SEL_W-1:0] o_fwd_rs_sel,
    output logic [SEL_W-1:0] o_fwd_rt_sel,
    output logic             o_atomic,
    output logic             o_sc_mask
);

    typedef struct packed {
        logic       valid;
        logic       load;
        logic [4:0] waddr;
    } entry_t;

    // r_ent[0] is S1 (youngest), r_ent[NUM_STAGES-1] is SN (oldest).
    entry_t r_ent [NUM_STAGES];

    logic [SEL_W:0]   w_rs_look;   // {hazard, stage select}
    logic [SEL_W:0]   w_rt_look;
    logic             w_stall;
    logic             w_issue;
    entry_t           w_new;

    // Scan oldest to youngest so the youngest matching entry is the one left
    // standing; its readiness alone decides forward versus hazard.
    function automatic logic [SEL_W:0] f_lookup(input logic       used,
                                                input logic [4:0] addr);
        logic [SEL_W-1:0] sel;
        logic             haz;
        sel = '0;
        haz = 1'b0;
        for (int k = NUM_STAGES; k >= 1; k--) begin
            if (used && addr != 5'd0 && r_ent[k-1].valid &&
                r_ent[k-1].waddr == addr) begin
                sel = SEL_W'(k);
                haz = r_ent[k-1].load && (k < LOAD_READY);
            end
        end
        return {haz, sel};
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a value before any condition,
        // so no path leaves it unassigned and no latch is inferred.
        w_rs_look    = f_lookup(i_id_rs_used, i_id_rs_addr);
        w_rt_look    = f_lookup(i_id_rt_used, i_id_rt_addr);
        w_stall      = i_id_valid & (w_rs_look[SEL_W] | w_rt_look[SEL_W]);
        o_stall      = w_stall;
        o_fwd_rs_sel = w_stall ? '0 : w_rs_look[SEL_W-1:0];
        o_fwd_rt_sel = w_stall ? '0 : w_rt_look[SEL_W-1:0];

        // $0 is never a real destination, so it enters as a bubble.
        w_issue      = i_id_valid & ~w_stall;
        w_new        = '0;
        if (w_issue && i_id_we && i_id_waddr != 5'd0) begin
            w_new.valid = 1'b1;
            w_new.load  = i_id_load;
            w_new.waddr = i_id_waddr;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's pre-edge value and the shift is order-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_STAGES; k++) r_ent[k] <= '0;
        end else if (i_flush) begin
            for (int k = 0; k < NUM_STAGES; k++) r_ent[k] <= '0;
        end else begin
            r_ent[0] <= w_new;
            for (int k = 1; k < NUM_STAGES; k++) r_ent[k] <= r_ent[k-1];
        end
    end

`ifdef SCOREBOARD_ATOMIC_EN
    logic r_atomic;

    // Set has priority over clear; flush leaves the link alone because the
    // link tracks memory state, not pipeline contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_atomic <= 1'b0;
        end else if (w_issue && i_id_ll) begin
            r_atomic <= 1'b1;
        end else if ((w_issue && (i_id_store || i_id_sc)) || i_snoop_inv) begin
            r_atomic <= 1'b0;
        end
    end

    assign o_atomic  = r_atomic;
    assign o_sc_mask = i_id_valid & i_id_sc & ~r_atomic;
`else
    // Without the link register every SC stores; these inputs have no use.
    logic w_unused_atomic;
    assign w_unused_atomic = ^{i_id_ll, i_id_sc, i_id_store, i_snoop_inv};
    assign o_atomic        = 1'b0;
    assign o_sc_mask       = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    localparam int NUM_STAGES = 3;
    localparam int LOAD_READY = 2;
    localparam int SEL_W      = $clog2(NUM_STAGES + 1);
`ifdef SCOREBOARD_ATOMIC_EN
    localparam logic ATOMIC_EN = 1'b1;
`else
    localparam logic ATOMIC_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid, id_rs_used, id_rt_used, id_we;
    logic [4:0]       id_rs_addr, id_rt_addr, id_waddr;
    logic             id_load, id_ll, id_sc, id_store, flush, snoop_inv;
    logic             stall, atomic, sc_mask;
    logic [SEL_W-1:0] fwd_rs_sel, fwd_rt_sel;

    int n_checks = 0;
    int n_pass   = 0;

    hazard_scoreboard #(.NUM_STAGES(NUM_STAGES), .LOAD_READY(LOAD_READY)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_id_valid   (id_valid),
        .i_id_rs_addr (id_rs_addr),
        .i_id_rt_addr (id_rt_addr),
        .i_id_rs_used (id_rs_used),
        .i_id_rt_used (id_rt_used),
        .i_id_we      (id_we),
        .i_id_waddr   (id_waddr),
        .i_id_load    (id_load),
        .i_id_ll      (id_ll),
        .i_id_sc      (id_sc),
        .i_id_store   (id_store),
        .i_flush      (flush),
        .i_snoop_inv  (snoop_inv),
        .o_stall      (stall),
        .o_fwd_rs_sel (fwd_rs_sel),
        .o_fwd_rt_sel (fwd_rt_sel),
        .o_atomic     (atomic),
        .o_sc_mask    (sc_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic idle();
        id_valid = 0; id_rs_used = 0; id_rt_used = 0; id_we = 0;
        id_rs_addr = 0; id_rt_addr = 0; id_waddr = 0;
        id_load = 0; id_ll = 0; id_sc = 0; id_store = 0;
        flush = 0; snoop_inv = 0;
    endtask

    // Advance one edge, then settle 1ns so inputs change away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writer(input logic [4:0] wa, input logic ld);
        idle();
        id_valid = 1; id_we = 1; id_waddr = wa; id_load = ld;
    endtask

    task automatic reader(input logic rsu, input logic [4:0] rs,
                          input logic rtu, input logic [4:0] rt);
        idle();
        id_valid = 1; id_rs_used = rsu; id_rs_addr = rs;
        id_rt_used = rtu; id_rt_addr = rt;
    endtask

    task automatic drain();
        idle();
        repeat (NUM_STAGES) tick();
    endtask

    initial begin
        // Reset state, with an SC in ID to see sc_mask under reset.
        rst = 1;
        idle();
        id_valid = 1; id_sc = 1;
        #2;
        check("rst_stall", stall, 0);
        check("rst_rs_sel", fwd_rs_sel, 0);
        check("rst_rt_sel", fwd_rt_sel, 0);
        check("rst_atomic", atomic, 0);
        check("rst_sc_mask", sc_mask, ATOMIC_EN);
        idle();
        #1 rst = 0;
        tick();

        // ALU result forwarded from S1.
        writer(5, 0);
        tick();
        reader(1, 5, 1, 3);
        #1;
        check("alu_fwd_stall", stall, 0);
        check("alu_fwd_rs", fwd_rs_sel, 1);
        check("alu_fwd_rt", fwd_rt_sel, 0);
        tick();
        drain();

        // Load-use: one stall cycle, then forward from S2.
        writer(7, 1);
        tick();
        reader(1, 1, 1, 7);
        #1;
        check("ldu_stall", stall, 1);
        check("ldu_rt_zero", fwd_rt_sel, 0);
        tick();
        #1;
        check("ldu_stall2", stall, 0);
        check("ldu_rt_s2", fwd_rt_sel, 2);
        check("ldu_rs_rf", fwd_rs_sel, 0);
        tick();
        drain();

        // Youngest match governs; $0 destination enters as a bubble.
        writer(4, 0); tick();
        writer(6, 0); tick();
        writer(4, 0); tick();
        reader(1, 4, 1, 6);
        id_we = 1; id_waddr = 0;
        #1;
        check("young_rs", fwd_rs_sel, 1);
        check("young_rt", fwd_rt_sel, 2);
        check("young_stall", stall, 0);
        tick();
        reader(1, 0, 1, 4);
        #1;
        check("zero_rs", fwd_rs_sel, 0);
        check("zero_rt_s2", fwd_rt_sel, 2);
        tick();
        drain();

        // Load at S3 (beyond LOAD_READY) forwards; unused source never stalls.
        writer(3, 1); tick();
        idle(); tick(); tick();
        reader(1, 1, 1, 3);
        #1;
        check("ld_s3_rt", fwd_rt_sel, 3);
        check("ld_s3_stall", stall, 0);
        tick();
        drain();
        writer(8, 1); tick();
        reader(0, 8, 0, 8);
        #1;
        check("unused_stall", stall, 0);
        tick();
        drain();

        // Flush: stall still seen this cycle, entries gone next cycle.
        writer(9, 1); tick();
        reader(1, 9, 0, 0);
        flush = 1;
        #1;
        check("flush_stall_now", stall, 1);
        tick();
        flush = 0;
        #1;
        check("flush_stall_next", stall, 0);
        check("flush_rs", fwd_rs_sel, 0);
        tick();
        drain();

        // Link flag and SC suppression.
        idle(); id_valid = 1; id_ll = 1; id_load = 1; id_we = 1; id_waddr = 2;
        tick();
        check("ll_atomic", atomic, ATOMIC_EN);
        idle(); id_valid = 1; id_store = 1;
        tick();
        check("sw_clear", atomic, 0);
        idle(); id_valid = 1; id_sc = 1;
        #1;
        check("sc_after_sw", sc_mask, ATOMIC_EN);
        tick();
        idle(); id_valid = 1; id_ll = 1;
        tick();
        idle(); id_valid = 1; id_sc = 1;
        #1;
        check("sc_linked", sc_mask, 0);
        tick();
        check("sc_clears", atomic, 0);
        idle(); id_valid = 1; id_ll = 1; snoop_inv = 1;
        tick();
        check("ll_snoop_set", atomic, ATOMIC_EN);
        idle(); snoop_inv = 1;
        tick();
        check("snoop_clear", atomic, 0);
        drain();

        // Asynchronous reset mid-stream wipes S1..S3.
        writer(10, 0); tick();
        writer(11, 0); tick();
        writer(12, 1); tick();
        reader(1, 12, 1, 10);
        #1;
        check("pre_rst_stall", stall, 1);
        rst = 1;
        #1;
        check("in_rst_stall", stall, 0);
        rst = 0;
        #1;
        check("post_rst_stall", stall, 0);
        check("post_rst_rs", fwd_rs_sel, 0);
        check("post_rst_rt", fwd_rt_sel, 0);
        writer(13, 0);
        tick();
        reader(1, 13, 1, 12);
        #1;
        check("post_rst_s1", fwd_rs_sel, 1);
        check("post_rst_stale", fwd_rt_sel, 0);
        tick();

        idle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
